// File: rtl/cpu_defs.sv
// Shared CPU definitions: reset/exception vectors, inter-stage bus widths
// and the fetch-stage state encoding.
package cpu_defs;

   localparam logic [31:0] RESET_PC       = 32'hBFC0_0000;
   localparam logic [31:0] EXC_ENTER_ADDR = 32'hBFC0_0380;

   localparam int IF_ID_BUS_W = 65;
   localparam int EXC_BUS_W   = 33;
   localparam int JBR_BUS_W   = 33;

   localparam logic [1:0] FS_REQ     = 2'd0;
   localparam logic [1:0] FS_WAIT    = 2'd1;
   localparam logic [1:0] FS_HOLD    = 2'd2;
   localparam logic [1:0] FS_DISCARD = 2'd3;

   typedef enum logic [1:0] {
      S_REQ     = FS_REQ,
      S_WAIT    = FS_WAIT,
      S_HOLD    = FS_HOLD,
      S_DISCARD = FS_DISCARD
   } fetch_state_e;

endpackage

// File: rtl/if_fetch_if.sv
// SRAM-like instruction port: req/addr_ok request phase, data_ok/rdata
// response phase. The fetch stage is the master.
interface if_fetch_if;

   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   modport master (
      output inst_req, inst_addr,
      input  inst_addr_ok, inst_data_ok, inst_rdata
   );

   modport slave (
      input  inst_req, inst_addr,
      output inst_addr_ok, inst_data_ok, inst_rdata
   );

endinterface

// File: rtl/if_pc_gen.sv
// Next-PC selection for the fetch stage: sequential step or a pending
// branch target captured from ID, applied after the delay slot.
module if_pc_gen
   import cpu_defs::*;
#(
   parameter logic [31:0] STEP = 32'd4
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [31:0]          pc,
   input  logic [JBR_BUS_W-1:0] jbr_bus,
   input  logic                 flush,
   input  logic                 consume,
   output logic [31:0]          next_pc
);

   logic        jbr_taken;
   logic [31:0] jbr_target;
   logic        br_pend;
   logic [31:0] br_target;

   assign {jbr_taken, jbr_target} = jbr_bus;

   // Only the registered copy steers next_pc, so a branch arriving during a
   // handoff redirects the fetch after the one being started.
   assign next_pc = br_pend ? br_target : pc + STEP;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         br_pend <= 1'b0;
      end else if (flush) begin
         br_pend <= 1'b0;
      end else if (jbr_taken) begin
         br_pend <= 1'b1;
      end else if (consume) begin
         br_pend <= 1'b0;
      end
   end

   // NOTE: br_target is data qualified by br_pend, so it carries no reset.
   always_ff @(posedge clk) begin
      if (!flush && jbr_taken) begin
         br_target <= jbr_target;
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over the SRAM-like port and
// hands {adel, pc, inst} to ID. Define FETCH_PERF_CNT_EN for perf counters.
module if_fetch #(
   parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic [cpu_defs::EXC_BUS_W-1:0]   exc_bus,
   input  logic                             cancel,
   input  logic [cpu_defs::JBR_BUS_W-1:0]   jbr_bus,
   input  logic                             ID_allow_in,
   if_fetch_if.master                       inst_if,
   output logic                             IF_over,
   output logic [cpu_defs::IF_ID_BUS_W-1:0] IF_ID_bus,
   output logic [31:0]                      IF_pc,
   output logic [31:0]                      fetch_cnt,
   output logic [31:0]                      discard_cnt
);

   import cpu_defs::fetch_state_e, cpu_defs::S_REQ, cpu_defs::S_WAIT,
          cpu_defs::S_HOLD, cpu_defs::S_DISCARD, cpu_defs::IF_ID_BUS_W;

   logic                   exc_valid;
   logic [31:0]            exc_pc;
   fetch_state_e           state, state_n;
   logic [31:0]            pc, pc_n, next_pc;
   logic [IF_ID_BUS_W-1:0] bus_q, bus_n;
   logic                   req, handoff, drop, flush_hold;

   assign {exc_valid, exc_pc} = exc_bus;

   if_pc_gen #(.STEP(PC_STEP)) u_pc_gen (
      .clk     (clk),
      .resetn  (resetn),
      .pc      (pc),
      .jbr_bus (jbr_bus),
      .flush   (exc_valid | cancel),
      .consume (handoff),
      .next_pc (next_pc)
   );

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      bus_n      = bus_q;
      req        = 1'b0;
      handoff    = 1'b0;
      drop       = 1'b0;
      flush_hold = 1'b0;
      case (state)
         S_REQ: begin
            if (pc[1:0] != 2'b00) begin
               state_n = S_HOLD;
               bus_n   = {1'b1, pc, 32'd0};
            end else begin
               req = 1'b1;
               if (inst_if.inst_addr_ok) state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (inst_if.inst_data_ok) begin
               state_n = S_HOLD;
               bus_n   = {1'b0, pc, inst_if.inst_rdata};
            end
         end
         S_HOLD: begin
            if (ID_allow_in) begin
               handoff = 1'b1;
               pc_n    = next_pc;
               state_n = S_REQ;
            end
         end
         S_DISCARD: begin
            if (inst_if.inst_data_ok) begin
               drop    = 1'b1;
               state_n = S_REQ;
            end
         end
         default: state_n = S_REQ;
      endcase

      // An exception redirect wins; an accepted request still owes a data_ok.
      if (exc_valid) begin
         pc_n    = exc_pc;
         bus_n   = bus_q;
         handoff = 1'b0;
         case (state)
            S_REQ:     state_n = (req && inst_if.inst_addr_ok) ? S_DISCARD : S_REQ;
            S_WAIT: begin
               drop    = inst_if.inst_data_ok;
               state_n = inst_if.inst_data_ok ? S_REQ : S_DISCARD;
            end
            S_HOLD: begin
               flush_hold = 1'b1;
               state_n    = S_REQ;
            end
            S_DISCARD: state_n = inst_if.inst_data_ok ? S_REQ : S_DISCARD;
            default:   state_n = S_REQ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values computed by the combinational block.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= S_REQ;
         pc    <= RESET_PC;
         bus_q <= '0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         bus_q <= bus_n;
      end
   end

   assign inst_if.inst_req  = req & resetn;
   assign inst_if.inst_addr = pc;
   assign IF_over           = (state == S_HOLD) && !exc_valid;
   assign IF_ID_bus         = bus_q;
   assign IF_pc             = pc;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_q, discard_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         fetch_q   <= '0;
         discard_q <= '0;
      end else begin
         if (handoff)           fetch_q   <= fetch_q + 32'd1;
         if (drop | flush_hold) discard_q <= discard_q + 32'd1;
      end
   end

   assign fetch_cnt   = fetch_q;
   assign discard_cnt = discard_q;
`else
   logic unused_perf;
   assign unused_perf = drop ^ flush_hold;
   assign fetch_cnt   = 32'd0;
   assign discard_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a memory model checks each accepted fetch
// address and a monitor checks every IF->ID handoff against queued values.
module tb_if_fetch;
   import cpu_defs::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [32:0] exc_bus = '0;
   logic        cancel = 1'b0;
   logic [32:0] jbr_bus = '0;
   logic        ID_allow_in = 1'b1;
   logic        IF_over;
   logic [64:0] IF_ID_bus;
   logic [31:0] IF_pc, fetch_cnt, discard_cnt;

   if_fetch_if mif ();

   if_fetch dut (
      .clk         (clk),
      .resetn      (resetn),
      .exc_bus     (exc_bus),
      .cancel      (cancel),
      .jbr_bus     (jbr_bus),
      .ID_allow_in (ID_allow_in),
      .inst_if     (mif),
      .IF_over     (IF_over),
      .IF_ID_bus   (IF_ID_bus),
      .IF_pc       (IF_pc),
      .fetch_cnt   (fetch_cnt),
      .discard_cnt (discard_cnt)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_addr[$];
   logic [64:0] exp_bus[$];
   logic        pend = 1'b0;
   logic        mem_stall = 1'b0;
   logic [31:0] pend_addr = '0;
   logic [31:0] acc_addr = '0;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic [31:0] perf(input logic [31:0] n);
`ifdef FETCH_PERF_CNT_EN
      return n;
`else
      return 32'd0 & n;
`endif
   endfunction

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_hold(input logic [31:0] a);
      int n = 0;
      while (!(IF_over && IF_ID_bus[63:32] == a) && n < 60) begin
         tick();
         n++;
      end
      check("hold_reached", 65'({IF_over, IF_ID_bus[63:32]}), 65'({1'b1, a}));
   endtask

   // Memory model: addr_ok whenever idle, data_ok one cycle later unless stalled.
   always @(negedge clk) begin
      if (!resetn) begin
         pend             = 1'b0;
         mif.inst_addr_ok = 1'b0;
         mif.inst_data_ok = 1'b0;
         mif.inst_rdata   = '0;
      end else begin
         if (mif.inst_data_ok) pend = 1'b0;
         if (mif.inst_addr_ok) begin
            pend      = 1'b1;
            pend_addr = acc_addr;
         end
         mif.inst_data_ok = pend && !mem_stall;
         mif.inst_rdata   = pend ? word_of(pend_addr) : 32'd0;
         mif.inst_addr_ok = mif.inst_req && !pend;
         if (mif.inst_addr_ok) begin
            acc_addr = mif.inst_addr;
            if (exp_addr.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL fetch_addr: got %h expected none", mif.inst_addr);
            end else begin
               check("fetch_addr", 65'(mif.inst_addr), 65'(exp_addr.pop_front()));
            end
         end
      end
   end

   // Handoff monitor.
   always @(negedge clk) begin
      if (resetn && IF_over && ID_allow_in) begin
         if (exp_bus.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL if_id_bus: got %h expected none", IF_ID_bus);
         end else begin
            check("if_id_bus", IF_ID_bus, exp_bus.pop_front());
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] addrs[13];
      logic [31:0] outs[11];
      addrs = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC00100, 32'hBFC00104,
                32'hBFC00108, 32'hBFC0000C, 32'hBFC00010, 32'hBFC00380, 32'hBFC00384,
                32'hBFC00380, 32'hBFC00384, 32'hBFC00388};
      outs  = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC00100, 32'hBFC00104,
                32'hBFC00108, 32'hBFC0000C, 32'hBFC00380, 32'hBFC00384, 32'hBFC00380,
                32'hBFC00384};
      foreach (addrs[i]) exp_addr.push_back(addrs[i]);
      foreach (outs[i]) exp_bus.push_back({1'b0, outs[i], word_of(outs[i])});

      // Reset state.
      repeat (2) tick();
      check("rst_inst_req", 65'(mif.inst_req), 65'(0));
      check("rst_if_over", 65'(IF_over), 65'(0));
      check("rst_if_id_bus", IF_ID_bus, 65'(0));
      check("rst_if_pc", 65'(IF_pc), 65'(32'hBFC00000));
      check("rst_fetch_cnt", 65'(fetch_cnt), 65'(0));
      check("rst_discard_cnt", 65'(discard_cnt), 65'(0));
      resetn = 1'b1;

      // Branch while holding the 04 instruction: 08 follows, then the target.
      wait_hold(32'hBFC00004);
      jbr_bus = {1'b1, 32'hBFC00100};
      tick();
      jbr_bus = '0;
      wait_hold(32'hBFC00104);
      jbr_bus = {1'b1, 32'hBFC0000C};
      tick();
      jbr_bus = '0;

      // Exception while waiting on the fetch of 10.
      wait_hold(32'hBFC0000C);
      mem_stall = 1'b1;
      for (int n = 0; n < 20 && !(pend && pend_addr == 32'hBFC00010); n++) tick();
      check("stall_wait", 65'({pend, pend_addr}), 65'({1'b1, 32'hBFC00010}));
      exc_bus = {1'b1, EXC_ENTER_ADDR};
      cancel  = 1'b1;
      tick();
      exc_bus = '0;
      cancel  = 1'b0;
      check("discard_if_over", 65'(IF_over), 65'(0));
      check("discard_inst_req", 65'(mif.inst_req), 65'(0));
      check("discard_pc", 65'(IF_pc), 65'(EXC_ENTER_ADDR));
      repeat (2) tick();
      check("discard_if_over_late", 65'(IF_over), 65'(0));
      mem_stall = 1'b0;
      wait_hold(32'hBFC00380);
      check("discard_cnt_1", 65'(discard_cnt), 65'(perf(1)));
      check("fetch_cnt_7", 65'(fetch_cnt), 65'(perf(7)));

      // Misaligned branch target: no request, adel reported and held.
      jbr_bus = {1'b1, 32'hBFC00102};
      tick();
      jbr_bus = '0;
      wait_hold(32'hBFC00384);
      tick();
      ID_allow_in = 1'b0;
      wait_hold(32'hBFC00102);
      for (int i = 0; i < 5; i++) begin
         check("adel_bus", IF_ID_bus, {1'b1, 32'hBFC00102, 32'd0});
         check("adel_over", 65'(IF_over), 65'(1));
         check("adel_no_req", 65'(mif.inst_req), 65'(0));
         check("adel_pc", 65'(IF_pc), 65'(32'hBFC00102));
         tick();
      end

      // Simultaneous exception and branch: exception wins, branch is lost.
      exc_bus = {1'b1, EXC_ENTER_ADDR};
      cancel  = 1'b1;
      jbr_bus = {1'b1, 32'hBFC00200};
      #1;
      check("exc_forces_over_0", 65'(IF_over), 65'(0));
      tick();
      exc_bus     = '0;
      cancel      = 1'b0;
      jbr_bus     = '0;
      ID_allow_in = 1'b1;
      check("exc_pc", 65'(IF_pc), 65'(EXC_ENTER_ADDR));
      wait_hold(32'hBFC00380);
      check("discard_cnt_2", 65'(discard_cnt), 65'(perf(2)));
      wait_hold(32'hBFC00384);
      wait_hold(32'hBFC00388);
      ID_allow_in = 1'b0;
      repeat (4) tick();

      check("final_bus", IF_ID_bus, {1'b0, 32'hBFC00388, word_of(32'hBFC00388)});
      check("final_over", 65'(IF_over), 65'(1));
      check("final_no_req", 65'(mif.inst_req), 65'(0));
      check("addr_queue_empty", 65'(exp_addr.size()), 65'(0));
      check("bus_queue_empty", 65'(exp_bus.size()), 65'(0));
      check("final_fetch_cnt", 65'(fetch_cnt), 65'(perf(11)));
      check("final_discard_cnt", 65'(discard_cnt), 65'(perf(2)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; it is the consumer end of the WB-generated exc_bus/cancel redirect.
- Owns the PC and issues requests on an SRAM-like instruction port (req/addr_ok/data_ok).
- Delivers {pc, inst, adel} to ID. It redirects on branch (jbr_bus, after the delay slot) and on exception/ERET (exc_bus), discarding in-flight fetches.

Parameters:
- RESET_PC, 32'hBFC00000, PC loaded on reset.
- PC_STEP, 32'd4, sequential increment.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- exc_bus  in  33  {exc_valid, exc_pc}; from WB
- cancel  in  1  flush from WB; same cycle as exc_valid
- jbr_bus  in  33  {jbr_taken, jbr_target}; from ID
- ID_allow_in  in  1  ID can accept this cycle
- inst_req  out  1  fetch request
- inst_addr  out  32  fetch address
- inst_addr_ok  in  1  request accepted
- inst_data_ok  in  1  read data valid
- inst_rdata  in  32  instruction word
- IF_over  out  1  IF_ID_bus valid
- IF_ID_bus  out  65  {adel, pc[31:0], inst[31:0]}
- IF_pc  out  32  PC for display
- fetch_cnt  out  32  perf counter (optional feature)
- discard_cnt  out  32  perf counter (optional feature)

Behaviour:
- Reset values:
  - pc = RESET_PC, state = REQ, br_pend = 0.
  - inst_req = 0 in the reset cycle; IF_over = 0; IF_ID_bus = 0.
  - Counters = 0.
- States: REQ, WAIT, HOLD, DISCARD.
- REQ:
  - If pc[1:0] != 0: no request. Go to HOLD with adel = 1, inst = 0.
  - Otherwise inst_req = 1, inst_addr = pc.
  - inst_addr_ok -> WAIT. inst_req stays high until addr_ok.
- WAIT:
  - inst_data_ok -> capture inst_rdata, go to HOLD. Minimum latency: addr_ok cycle N, data_ok N+1 or later.
- HOLD:
  - IF_over = 1.
  - On ID_allow_in: pc <= next_pc, go to REQ. The handoff takes one cycle.
  - IF_ID_bus is stable while held.
- Next PC: next_pc = br_pend ? br_target : pc + PC_STEP. br_pend clears when used.
- Branch capture:
  - jbr_taken is sampled in any cycle when not cancelled; this sets br_pend and latches the target.
  - The instruction currently in IF is the delay slot; the redirect applies to the fetch after it.
  - If jbr_taken and HOLD→REQ happen in the same cycle: the transition uses pc + 4 (the delay slot is the current instruction). The target applies to the next transition.
- Exception redirect:
  - exc_valid overrides everything: pc <= exc_pc, br_pend <= 0, IF_over forced 0 that cycle.
  - From HOLD or REQ-without-addr_ok: go to REQ.
  - From WAIT, or REQ with addr_ok in the same cycle: go to DISCARD.
  - exc_valid takes priority over a simultaneous jbr_taken.
- DISCARD:
  - inst_req = 0.
  - On inst_data_ok: drop the data, go to REQ at the redirected pc.
  - A second exc_valid in DISCARD updates pc and stays in DISCARD.
- Other rules:
  - At most one outstanding request.
  - PC arithmetic is modulo 2^32; wrap from 0xFFFFFFFC to 0.
  - Reset mid-WAIT returns to REQ at RESET_PC. The memory side is also reset, so no discard is needed.
- Port functions: IF_pc = pc.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - fetch_cnt increments on each HOLD→REQ handoff to ID.
  - discard_cnt increments on each dropped data_ok in DISCARD, and on each flush of a HOLD instruction.
  - Both counters wrap modulo 2^32.
- Undefined: both ports tied to 32'd0 and no counter flops. Port list is unchanged.

Decomposition:
- Shared package cpu_defs:
  - RESET_PC, EXC_ENTER_ADDR.
  - Bus widths: IF_ID_BUS_W=65, EXC_BUS_W=33, JBR_BUS_W=33.
  - Fetch state encoding localparams.
- Sub-module: if_pc_gen (combinational next_pc plus br_pend register). The FSM stays in if_fetch.

Test Plan:
- Reset release, memory addr_ok/data_ok with 1-cycle latency, ID_allow_in = 1 -> inst_addr sequence BFC00000, BFC00004, BFC00008. IF_ID_bus.pc matches each address; adel = 0.
- jbr_taken, target 0xBFC00100, asserted while IF holds pc BFC00004 -> next fetches BFC00008 (delay slot), then BFC00100.
- exc_valid with exc_pc BFC00380 while in WAIT for BFC00010 -> data_ok for BFC00010 dropped (IF_over stays 0). Next inst_addr = BFC00380. discard_cnt = 1 with FETCH_PERF_CNT_EN.
- jbr target 0xBFC00102 -> no inst_req for it. IF_ID_bus = {1, BFC00102, 0}, IF_over = 1.
- ID_allow_in held 0 for 5 cycles in HOLD -> IF_ID_bus constant, inst_req = 0, no PC change.
- Same-cycle exc_valid (BFC00380) and jbr_taken (BFC00200) -> pc = BFC00380, br_pend cleared. BFC00200 is never fetched.
